cfs_regs_mc: RTL and testbench

Multi-channel APB register block for the next-generation aligner. It holds CTRL, STATUS, IRQEN and IRQ registers for each of NUM_CH aligner channels, plus one global IRQ summary register. Each register group is replicated per channel. The APB response latency is configurable, and a single interrupt output is produced from sticky, maskable per-channel event flags. It sits between the APB interconnect and NUM_CH aligner datapath cores.

---
 rtl/cfs_regs_mc.sv | 246 ++++++++++++++++++++++++
 tb/tb_cfs_regs_mc.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cfs_regs_mc.sv
// cfs_regs_mc: multi-channel APB register block for the aligner.
// Per channel: CTRL, STATUS, IRQEN and IRQ; one global IRQ summary at 0xFFC.
// Sticky IRQ bits are set on rising edges of the per-channel event levels.
//
// state  | meaning
// S_IDLE | waiting for psel & penable; access fields tracked live
// S_WAIT | counting configured wait states down to zero
// S_ERRW | extra cycle charged to an illegal CTRL write
// S_RESP | pready high; register writes commit on the closing edge
module cfs_regs_mc #(
  parameter int APB_ADDR_WIDTH        = 16,
  parameter int ALGN_DATA_WIDTH       = 32,
  parameter int NUM_CH                = 4,
  parameter int WAIT_STATES           = 0,
  parameter int STATUS_CNT_DROP_WIDTH = 8,
  parameter int STATUS_RX_LVL_WIDTH   = 4,
  parameter int STATUS_TX_LVL_WIDTH   = 4,
  localparam int DATA_BYTES = ALGN_DATA_WIDTH / 8,
  localparam int OFF_W      = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(DATA_BYTES),
  localparam int SIZE_W     = $clog2(DATA_BYTES) + 1
) (
  input  logic                                    pclk,
  input  logic                                    preset,
  input  logic [APB_ADDR_WIDTH-1:0]               paddr,
  input  logic                                    psel,
  input  logic                                    penable,
  input  logic                                    pwrite,
  input  logic [31:0]                             pwdata,
  output logic                                    pready,
  output logic                                    pslverr,
  output logic [31:0]                             prdata,
  output logic [NUM_CH*OFF_W-1:0]                 ctrl_offset,
  output logic [NUM_CH*SIZE_W-1:0]                ctrl_size,
  output logic [NUM_CH-1:0]                       ctrl_clr,
  input  logic [NUM_CH*STATUS_CNT_DROP_WIDTH-1:0] status_cnt_drop,
  input  logic [NUM_CH*STATUS_RX_LVL_WIDTH-1:0]   status_rx_lvl,
  input  logic [NUM_CH*STATUS_TX_LVL_WIDTH-1:0]   status_tx_lvl,
  input  logic [NUM_CH-1:0]                       rx_fifo_empty,
  input  logic [NUM_CH-1:0]                       rx_fifo_full,
  input  logic [NUM_CH-1:0]                       tx_fifo_empty,
  input  logic [NUM_CH-1:0]                       tx_fifo_full,
  input  logic [NUM_CH-1:0]                       max_drop,
  output logic                                    irq
);

  localparam int CDW = STATUS_CNT_DROP_WIDTH;
  localparam int RXW = STATUS_RX_LVL_WIDTH;
  localparam int TXW = STATUS_TX_LVL_WIDTH;
  localparam int LW  = 8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERRW, S_RESP} state_t;

  state_t r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;

  logic [APB_ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [31:0]               r_wdata, w_wdata;
  logic                      r_write, w_write;

  logic [SIZE_W-1:0] r_size  [NUM_CH];
  logic [OFF_W-1:0]  r_off   [NUM_CH];
  logic [4:0]        r_irqen [NUM_CH];
  logic [4:0]        r_irq   [NUM_CH];
  logic [4:0]        r_ev_q  [NUM_CH];
  logic [4:0]        w_ev    [NUM_CH];
  logic [4:0]        w_w1c   [NUM_CH];
  logic [NUM_CH-1:0] w_pend;

  logic        r_pready, r_pslverr;
  logic [31:0] r_prdata, w_rdata;

  logic [3:0]    w_ch;
  logic [5:0]    w_off;
  logic          w_is_sum, w_ch_ok, w_mapped, w_dec_err, w_illegal, w_wr;
  logic          w_sel_ctrl, w_sel_status, w_sel_irqen, w_sel_irq;
  logic [LW-1:0] w_wr_size, w_wr_sum, w_wr_div;
  logic          w_ctrl_legal;
  logic          w_unused;

  // While idle the live bus is decoded so a zero-wait access can answer at once;
  // afterwards the copy captured in the first access cycle is used.
  assign w_addr  = (r_state == S_IDLE) ? paddr  : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? pwdata : r_wdata;
  assign w_write = (r_state == S_IDLE) ? pwrite : r_write;
  assign w_unused = ^{w_addr, w_wdata};

  assign w_ch         = w_addr[11:8];
  assign w_off        = w_addr[7:2];
  assign w_is_sum     = (w_addr[11:2] == 10'h3FF);
  assign w_ch_ok      = (w_ch < 4'(NUM_CH));
  assign w_sel_ctrl   = (w_off == 6'h00);
  assign w_sel_status = (w_off == 6'h03);
  assign w_sel_irqen  = (w_off == 6'h3C);
  assign w_sel_irq    = (w_off == 6'h3D);
  assign w_mapped     = w_sel_ctrl | w_sel_status | w_sel_irqen | w_sel_irq;
  assign w_dec_err    = w_is_sum ? w_write
                                 : (!w_ch_ok || !w_mapped || (w_write && w_sel_status));

  // size must divide DATA_BYTES + offset; divisor forced nonzero to keep the divider defined
  assign w_wr_size    = LW'(w_wdata[SIZE_W-1:0]);
  assign w_wr_sum     = LW'(DATA_BYTES) + LW'(w_wdata[8 +: OFF_W]);
  assign w_wr_div     = (w_wr_size == '0) ? LW'(1) : w_wr_size;
  assign w_ctrl_legal = (w_wr_size != '0) && (w_wr_size <= LW'(DATA_BYTES))
                        && ((w_wr_sum % w_wr_div) == '0);
  assign w_illegal    = !w_dec_err && w_write && w_sel_ctrl && !w_ctrl_legal;

  assign w_wr = (r_state == S_RESP) && w_write && !w_dec_err && !w_illegal;

  // FSM state and wait counter register
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // FSM next state and wait counter load/decrement
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (psel && penable) begin
          if (WAIT_STATES == 0) begin
            w_state_nxt = w_illegal ? S_ERRW : S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = 3'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 3'd0) w_state_nxt = w_illegal ? S_ERRW : S_RESP;
        else               w_cnt_nxt   = r_cnt - 3'd1;
      end
      S_ERRW:  w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // capture the access fields during the first access cycle
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_addr  <= paddr;
      r_wdata <= pwdata;
      r_write <= pwrite;
    end
  end

  // read data mux, per channel and global summary
  always_comb begin
    w_rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch == 4'(c)) begin
        if (w_sel_ctrl) begin
          w_rdata[SIZE_W-1:0] = r_size[c];
          w_rdata[8 +: OFF_W] = r_off[c];
        end
        if (w_sel_status) begin
          w_rdata[0 +: CDW]  = status_cnt_drop[c*CDW +: CDW];
          w_rdata[8 +: RXW]  = status_rx_lvl[c*RXW +: RXW];
          w_rdata[16 +: TXW] = status_tx_lvl[c*TXW +: TXW];
        end
        if (w_sel_irqen) w_rdata[4:0] = r_irqen[c];
        if (w_sel_irq)   w_rdata[4:0] = r_irq[c];
      end
    end
    if (w_is_sum) begin
      w_rdata = '0;
      w_rdata[NUM_CH-1:0] = w_pend;
    end
  end

  // registered APB response, nonzero only in the RESP cycle
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_pready  <= (w_state_nxt == S_RESP);
      r_pslverr <= (w_state_nxt == S_RESP) && (w_dec_err || w_illegal);
      r_prdata  <= ((w_state_nxt == S_RESP) && !w_write && !w_dec_err) ? w_rdata : '0;
    end
  end

  // event vectors, W1C masks, enabled-pending summary and clear pulses
  always_comb begin
    w_pend   = '0;
    ctrl_clr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_ev[c]  = {max_drop[c], tx_fifo_full[c], tx_fifo_empty[c],
                  rx_fifo_full[c], rx_fifo_empty[c]};
      w_w1c[c] = (w_wr && w_sel_irq && (w_ch == 4'(c))) ? w_wdata[4:0] : 5'h00;
      w_pend[c] = |(r_irq[c] & r_irqen[c]);
      ctrl_clr[c] = w_wr && w_sel_ctrl && w_wdata[16] && (w_ch == 4'(c));
    end
  end

  // per-channel registers; a same-cycle event edge beats W1C
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_size[c]  <= SIZE_W'(1);
        r_off[c]   <= '0;
        r_irqen[c] <= 5'h1F;
        r_irq[c]   <= 5'h00;
        r_ev_q[c]  <= 5'b00101;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr && w_sel_ctrl && (w_ch == 4'(c))) begin
          r_size[c] <= w_wdata[SIZE_W-1:0];
          r_off[c]  <= w_wdata[8 +: OFF_W];
        end
        if (w_wr && w_sel_irqen && (w_ch == 4'(c))) r_irqen[c] <= w_wdata[4:0];
        r_irq[c]  <= (r_irq[c] & ~w_w1c[c]) | (w_ev[c] & ~r_ev_q[c]);
        r_ev_q[c] <= w_ev[c];
      end
    end
  end

  // flatten per-channel CTRL fields onto the output buses
  always_comb begin
    ctrl_size   = '0;
    ctrl_offset = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ctrl_size[c*SIZE_W +: SIZE_W] = r_size[c];
      ctrl_offset[c*OFF_W +: OFF_W] = r_off[c];
    end
  end

  assign pready  = r_pready;
  assign pslverr = r_pslverr;
  assign prdata  = r_prdata;
  assign irq     = |w_pend;

endmodule

// File: tb/tb_cfs_regs_mc.sv
// Bench for cfs_regs_mc: three instances (0, 3 and 7 wait states) share one APB
// bus with separate psel. The driver queues the expected response of each access;
// a monitor pops and compares whenever any instance raises pready.
module tb_cfs_regs_mc;

  typedef struct packed {
    logic [1:0]  dut;
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  lat;
    logic [3:0]  clr;
    logic [31:0] start;
    logic [15:0] id;
  } exp_t;

  logic        clk = 1'b0;
  logic        preset;
  logic [15:0] paddr;
  logic [2:0]  psel;
  logic        penable, pwrite;
  logic [31:0] pwdata;

  logic [2:0]  pready_v, pslverr_v, irq_v;
  logic [31:0] prdata_v      [3];
  logic [7:0]  ctrl_offset_v [3];
  logic [11:0] ctrl_size_v   [3];
  logic [3:0]  ctrl_clr_v    [3];

  logic [31:0] st_drop;
  logic [15:0] st_rx, st_tx;
  logic [3:0]  rx_empty, rx_full, tx_empty, tx_full, mdrop;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   n_id = 0;
  exp_t q[$];

  for (genvar d = 0; d < 3; d++) begin : g_dut
    cfs_regs_mc #(.WAIT_STATES((d == 0) ? 0 : ((d == 1) ? 3 : 7))) u_dut (
      .pclk(clk), .preset(preset), .paddr(paddr), .psel(psel[d]),
      .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
      .pready(pready_v[d]), .pslverr(pslverr_v[d]), .prdata(prdata_v[d]),
      .ctrl_offset(ctrl_offset_v[d]), .ctrl_size(ctrl_size_v[d]), .ctrl_clr(ctrl_clr_v[d]),
      .status_cnt_drop(st_drop), .status_rx_lvl(st_rx), .status_tx_lvl(st_tx),
      .rx_fifo_empty(rx_empty), .rx_fifo_full(rx_full),
      .tx_fifo_empty(tx_empty), .tx_fifo_full(tx_full), .max_drop(mdrop),
      .irq(irq_v[d]));
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (access %0d): got 0x%0h expected 0x%0h", nm, id, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (pready_v[d]) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pready: dut %0d raised pready with nothing outstanding", d);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("resp_dut", int'(e.id), 32'(d), 32'(e.dut));
          chk("prdata",   int'(e.id), prdata_v[d], e.rdata);
          chk("pslverr",  int'(e.id), 32'(pslverr_v[d]), 32'(e.err));
          chk("latency",  int'(e.id), 32'(cyc - int'(e.start)), 32'(e.lat));
          chk("ctrl_clr", int'(e.id), 32'(ctrl_clr_v[d]), 32'(e.clr));
        end
      end
    end
  end

  task automatic apb(input int d, input logic w, input logic [15:0] a, input logic [31:0] wd,
                     input logic [31:0] er, input logic ee, input int el, input logic [3:0] ec,
                     input bit ev_at_resp);
    exp_t e;
    bit   ok;
    @(negedge clk);
    psel = '0; psel[d] = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = wd;
    @(negedge clk);
    penable = 1'b1;
    n_id++;
    e.dut = 2'(d); e.rdata = er; e.err = ee; e.lat = 8'(el); e.clr = ec;
    e.start = 32'(cyc); e.id = 16'(n_id);
    q.push_back(e);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pready_v[d]) begin
        ok = 1'b1;
        if (ev_at_resp) tx_full[3] = 1'b1;
        break;
      end
    end
    psel = '0; penable = 1'b0;
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: access %0d on dut %0d got no pready", n_id, d);
      q.delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    preset = 1'b1; paddr = '0; psel = '0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
    st_drop = 32'h0000_5AA5; st_rx = 16'h0003; st_tx = 16'h000C;
    rx_empty = 4'hF; tx_empty = 4'hF; rx_full = '0; tx_full = '0; mdrop = '0;
    repeat (3) @(negedge clk);
    preset = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_irq",    0, 32'(irq_v), 32'h0);
    chk("rst_pready", 0, 32'(pready_v), 32'h0);
    chk("rst_size",   0, 32'(ctrl_size_v[0]), 32'h249);
    chk("rst_offset", 0, 32'(ctrl_offset_v[0]), 32'h0);
    chk("rst_prdata", 0, prdata_v[0], 32'h0);

    // reset reads
    apb(0, 0, 16'h000, 0, 32'h1,  0, 1, 4'h0, 0);
    apb(0, 0, 16'h0F0, 0, 32'h1F, 0, 1, 4'h0, 0);

    // legal CTRL write with clear on ch2: size 2, offset 2
    apb(0, 1, 16'h200, 32'h0001_0202, 32'h0, 0, 1, 4'b0100, 0);
    @(negedge clk);
    chk("clr_gone", 0, 32'(ctrl_clr_v[0]), 32'h0);
    apb(0, 0, 16'h200, 0, 32'h0000_0202, 0, 1, 4'h0, 0);
    chk("size_bus",   0, 32'(ctrl_size_v[0]), 32'h289);
    chk("offset_bus", 0, 32'(ctrl_offset_v[0]), 32'h20);

    // illegal CTRL writes on ch1: size 3, size 0, size 8
    apb(0, 1, 16'h100, 32'h0001_0003, 32'h0, 1, 2, 4'h0, 0);
    apb(0, 1, 16'h100, 32'h0001_0000, 32'h0, 1, 2, 4'h0, 0);
    apb(0, 1, 16'h100, 32'h0000_0008, 32'h0, 1, 2, 4'h0, 0);
    apb(0, 0, 16'h100, 0, 32'h1, 0, 1, 4'h0, 0);
    chk("size_kept", 0, 32'(ctrl_size_v[0]), 32'h289);

    // STATUS reads
    apb(0, 0, 16'h00C, 0, 32'h000C_03A5, 0, 1, 4'h0, 0);
    apb(0, 0, 16'h10C, 0, 32'h0000_005A, 0, 1, 4'h0, 0);

    // tx_fifo_full event on ch3
    @(negedge clk); tx_full[3] = 1'b1;
    @(negedge clk);
    chk("irq_set", 0, 32'(irq_v[0]), 32'h1);
    apb(0, 0, 16'h3F4, 0, 32'h08, 0, 1, 4'h0, 0);
    apb(0, 0, 16'hFFC, 0, 32'h08, 0, 1, 4'h0, 0);
    apb(0, 1, 16'h3F4, 32'h08, 32'h0, 0, 1, 4'h0, 0);
    @(negedge clk);
    chk("irq_w1c", 0, 32'(irq_v[0]), 32'h0);
    tx_full[3] = 1'b0;
    // edge coincident with W1C: set wins
    apb(0, 1, 16'h3F4, 32'h08, 32'h0, 0, 1, 4'h0, 1);
    @(negedge clk);
    chk("irq_setwins", 0, 32'(irq_v[0]), 32'h1);
    apb(0, 0, 16'h3F4, 0, 32'h08, 0, 1, 4'h0, 0);
    // mask ch3 through IRQEN
    apb(0, 1, 16'h3F0, 32'h00, 32'h0, 0, 1, 4'h0, 0);
    @(negedge clk);
    chk("irq_masked", 0, 32'(irq_v[0]), 32'h0);
    apb(0, 0, 16'hFFC, 0, 32'h00, 0, 1, 4'h0, 0);
    tx_full[3] = 1'b0;
    // max_drop on ch1
    mdrop[1] = 1'b1;
    @(negedge clk);
    mdrop[1] = 1'b0;
    chk("irq_maxdrop", 0, 32'(irq_v[0]), 32'h1);
    apb(0, 0, 16'h1F4, 0, 32'h10, 0, 1, 4'h0, 0);
    apb(0, 1, 16'h1F4, 32'h10, 32'h0, 0, 1, 4'h0, 0);
    @(negedge clk);
    chk("irq_maxdrop_clr", 0, 32'(irq_v[0]), 32'h0);

    // error completions
    apb(0, 0, 16'h400, 0, 32'h0, 1, 1, 4'h0, 0);
    apb(0, 1, 16'h400, 32'h0001_0001, 32'h0, 1, 1, 4'h0, 0);
    apb(0, 0, 16'h040, 0, 32'h0, 1, 1, 4'h0, 0);
    apb(0, 1, 16'h00C, 32'hFFFF_FFFF, 32'h0, 1, 1, 4'h0, 0);
    apb(0, 1, 16'hFFC, 32'hFFFF_FFFF, 32'h0, 1, 1, 4'h0, 0);

    // wait-state sweep
    apb(1, 0, 16'h000, 0, 32'h1, 0, 4, 4'h0, 0);
    apb(2, 0, 16'h000, 0, 32'h1, 0, 8, 4'h0, 0);
    apb(2, 1, 16'h000, 32'h3, 32'h0, 1, 9, 4'h0, 0);
    apb(1, 0, 16'h0F0, 0, 32'h1F, 0, 4, 4'h0, 0);

    // reset in the WAIT state of a CTRL write on the 3-wait instance
    @(negedge clk);
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 16'h000; pwdata = 32'h0001_0002;
    @(negedge clk);
    penable = 1'b1;
    repeat (2) @(negedge clk);
    preset = 1'b1;
    @(negedge clk);
    chk("abort_pready", 0, 32'(pready_v[1]), 32'h0);
    preset = 1'b0; psel = '0; penable = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_size", 0, 32'(ctrl_size_v[1]), 32'h249);
    chk("abort_clr",  0, 32'(ctrl_clr_v[1]), 32'h0);
    apb(1, 0, 16'h000, 0, 32'h1, 0, 4, 4'h0, 0);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL leftover: %0d expected responses never arrived", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
